// File: rtl/gmii_rx_framer_pkg.sv
// Shared definitions for the GMII receive framer: output codes, FSM states
// and the reflected CRC-32 helpers.
package gmii_rx_framer_pkg;

    typedef enum logic [1:0] {
        PCC_DATA   = 2'd0,
        PCC_SOP    = 2'd1,
        PCC_EOP    = 2'd2,
        PCC_BADEOP = 2'd3
    } pcc_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PRE,
        ST_DATA,
        ST_DROP
    } rx_state_t;

    localparam logic [7:0]  PRE_BYTE    = 8'h55;
    localparam logic [7:0]  SFD_BYTE    = 8'hD5;
    localparam logic [31:0] CRC_RESIDUE = 32'hC704DD7B;

    function automatic logic [31:0] crc32_next(input logic [31:0] crc, input logic [7:0] d);
        logic [31:0] c;
        c = crc ^ {24'h0, d};
        for (int i = 0; i < 8; i++)
            c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
        return c;
    endfunction

    // The register holds the CRC bit-reflected, so reverse it before comparing to the residue.
    function automatic logic crc_residue_ok(input logic [31:0] crc);
        logic [31:0] r;
        for (int i = 0; i < 32; i++)
            r[i] = crc[31-i];
        return (r == CRC_RESIDUE);
    endfunction

endpackage

// File: rtl/gmii_rx_framer_if.sv
// rxg code+data stream with srdy/drdy handshake between framer and packet parser.
interface gmii_rx_framer_if;
    import gmii_rx_framer_pkg::*;

    logic       srdy;
    logic       drdy;
    pcc_t       code;
    logic [7:0] data;

    modport master (output srdy, code, data, input drdy);
    modport slave  (input srdy, code, data, output drdy);

endinterface

// File: rtl/gmii_rx_framer_fifo.sv
// Ring-buffer FIFO for the rxg stream; one slot is kept unused so the pointer
// difference alone gives the occupancy, capacity is DEPTH-1.
module gmii_rx_framer_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 10
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     wr_en,
    input  logic [WIDTH-1:0]         wr_data,
    output logic                     rd_srdy,
    input  logic                     rd_drdy,
    output logic [WIDTH-1:0]         rd_data,
    output logic [$clog2(DEPTH)-1:0] free
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW-1:0] MAX_CNT = AW'(DEPTH - 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr, count;
    logic             rd_fire, wr_fire;

    assign count   = wr_ptr - rd_ptr;
    assign rd_srdy = (count != '0);
    assign rd_fire = rd_srdy && rd_drdy;
    assign wr_fire = wr_en && ((count != MAX_CNT) || rd_fire);
    assign free    = MAX_CNT - count;
    assign rd_data = mem[rd_ptr];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_fire) wr_ptr <= wr_ptr + AW'(1);
            if (rd_fire) rd_ptr <= rd_ptr + AW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (wr_fire) mem[wr_ptr] <= wr_data;
    end

endmodule

// File: rtl/gmii_rx_framer.sv
// GMII receive framer: strips preamble/SFD and FCS, checks CRC and length,
// and feeds the rxg stream through an output FIFO with frame-safe overflow.
module gmii_rx_framer
    import gmii_rx_framer_pkg::*;
#(
    parameter int DEPTH   = 16,
    parameter int MIN_LEN = 64
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             gmii_rx_dv,
    input  logic             gmii_rx_er,
    input  logic [7:0]       gmii_rxd,
    gmii_rx_framer_if.master rxg,
    output logic             crc_err,
    output logic [15:0]      drop_cnt
);
    localparam int AW = $clog2(DEPTH);

    rx_state_t     state, state_nx;
    logic [7:0]    dl [5];
    logic [2:0]    dl_cnt;
    logic [31:0]   crc;
    logic [11:0]   len;
    logic          bad, sop_done;
    logic          start, shift, set_sop, drop_inc, crc_err_nx, wr_en;
    pcc_t          wr_code;
    logic [AW-1:0] free;
    logic [9:0]    rd_word;
    logic          dl_full, crc_ok, eof_bad;

    assign dl_full = (dl_cnt == 3'd5);
    assign crc_ok  = crc_residue_ok(crc);
    assign eof_bad = bad || !crc_ok || (len < 12'(MIN_LEN));

    always_comb begin
        state_nx   = state;
        start      = 1'b0;
        shift      = 1'b0;
        set_sop    = 1'b0;
        drop_inc   = 1'b0;
        crc_err_nx = 1'b0;
        wr_en      = 1'b0;
        wr_code    = PCC_DATA;
        case (state)
            ST_IDLE, ST_PRE: begin
                if (!gmii_rx_dv) state_nx = ST_IDLE;
                else if (gmii_rx_er) begin
                    state_nx = ST_DROP;
                    drop_inc = 1'b1;
                end else if (gmii_rxd == SFD_BYTE) begin
                    state_nx = ST_DATA;
                    start    = 1'b1;
                end else if (gmii_rxd == PRE_BYTE) state_nx = ST_PRE;
                else begin
                    state_nx = ST_DROP;
                    drop_inc = 1'b1;
                end
            end
            ST_DATA: begin
                if (!gmii_rx_dv) begin
                    // Delay line now holds exactly the FCS plus the last payload byte.
                    state_nx = ST_IDLE;
                    if (dl_full && (sop_done || free != '0)) begin
                        wr_en      = 1'b1;
                        wr_code    = (eof_bad || !sop_done) ? PCC_BADEOP : PCC_EOP;
                        crc_err_nx = !crc_ok;
                    end else drop_inc = 1'b1;
                end else begin
                    shift = 1'b1;
                    if (dl_full) begin
                        wr_en = 1'b1;
                        if (!sop_done) begin
                            if (free > AW'(1)) begin
                                wr_code = PCC_SOP;
                                set_sop = 1'b1;
                            end else begin
                                wr_en    = 1'b0;
                                state_nx = ST_DROP;
                                drop_inc = 1'b1;
                            end
                        end else if (free <= AW'(1)) begin
                            // Last free slot: terminate the frame rather than lose its end.
                            wr_code  = PCC_BADEOP;
                            state_nx = ST_DROP;
                        end
                    end
                end
            end
            default: if (!gmii_rx_dv) state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= ST_IDLE;
            dl_cnt   <= '0;
            bad      <= 1'b0;
            sop_done <= 1'b0;
            crc_err  <= 1'b0;
            drop_cnt <= '0;
        end else begin
            state   <= state_nx;
            crc_err <= crc_err_nx;
            if (drop_inc && drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
            if (start) begin
                dl_cnt   <= '0;
                bad      <= 1'b0;
                sop_done <= 1'b0;
            end else if (shift) begin
                if (!dl_full) dl_cnt <= dl_cnt + 3'd1;
                if (gmii_rx_er) bad <= 1'b1;
                if (set_sop) sop_done <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (start) begin
            crc <= 32'hFFFFFFFF;
            len <= '0;
        end else if (shift) begin
            crc   <= crc32_next(crc, gmii_rxd);
            dl[0] <= gmii_rxd;
            for (int i = 1; i < 5; i++) dl[i] <= dl[i-1];
            if (len != 12'hFFF) len <= len + 12'd1;
        end
    end

    gmii_rx_framer_fifo #(.DEPTH(DEPTH), .WIDTH(10)) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .wr_en   (wr_en),
        .wr_data ({wr_code, dl[4]}),
        .rd_srdy (rxg.srdy),
        .rd_drdy (rxg.drdy),
        .rd_data (rd_word),
        .free    (free)
    );

    assign rxg.code = pcc_t'(rd_word[9:8]);
    assign rxg.data = rd_word[7:0];

endmodule

// File: tb/tb_gmii_rx_framer.sv
// Directed bench for gmii_rx_framer: table of single frames plus overflow,
// back-to-back and mid-frame reset sequences.
module tb_gmii_rx_framer;
    import gmii_rx_framer_pkg::*;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        gmii_rx_dv, gmii_rx_er;
    logic [7:0]  gmii_rxd;
    logic        crc_err;
    logic [15:0] drop_cnt;

    gmii_rx_framer_if rxg_if();

    gmii_rx_framer #(.DEPTH(16), .MIN_LEN(64)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .gmii_rx_dv (gmii_rx_dv),
        .gmii_rx_er (gmii_rx_er),
        .gmii_rxd   (gmii_rxd),
        .rxg        (rxg_if),
        .crc_err    (crc_err),
        .drop_cnt   (drop_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         len;
        bit         flip;
        int         er_idx;
        logic [7:0] sfd;
        int         n_exp;
        pcc_t       last;
        int         crc_errs;
        int         drops;
    } vec_t;

    int         nerr = 0;
    int         nchk = 0;
    int         crc_seen = 0;
    int         exp_drop = 0;
    logic [7:0] tx_b[$];
    bit         tx_er[$];
    pcc_t       rx_code[$];
    logic [7:0] rx_data[$];
    pcc_t       exp_code[$];
    logic [7:0] exp_data[$];
    vec_t       tbl[10];

    always @(negedge clk) begin
        if (reset_n && rxg_if.srdy && rxg_if.drdy) begin
            rx_code.push_back(rxg_if.code);
            rx_data.push_back(rxg_if.data);
        end
        if (crc_err) crc_seen++;
    end

    task automatic chk(input string name, input longint act, input longint exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // MSB-first CRC with LSB-first bit feed; FCS is the complement, bit-reversed.
    task automatic build_frame(input int len, input bit flip, input int er_idx,
                               input logic [7:0] sfd, input int seed,
                               input int n_exp, input pcc_t last);
        logic [7:0]  fr[$];
        logic [31:0] c, fcs;
        int          pay_n;
        bit          fb;
        tx_b.delete();
        tx_er.delete();
        for (int i = 0; i < 7; i++) begin tx_b.push_back(8'h55); tx_er.push_back(1'b0); end
        tx_b.push_back(sfd);
        tx_er.push_back(1'b0);
        pay_n = (len > 4) ? len - 4 : 0;
        c = 32'hFFFFFFFF;
        for (int i = 0; i < pay_n; i++) begin
            logic [7:0] b;
            b = 8'(i * 37 + seed * 11 + 3);
            fr.push_back(b);
            for (int k = 0; k < 8; k++) begin
                fb = c[31] ^ b[k];
                c  = c << 1;
                if (fb) c = c ^ 32'h04C11DB7;
            end
        end
        for (int i = 0; i < 32; i++) fcs[i] = ~c[31-i];
        for (int i = 0; i < 4; i++) fr.push_back(fcs[8*i +: 8]);
        if (flip) fr[pay_n] = fr[pay_n] ^ 8'hFF;
        for (int i = 0; i < len; i++) begin
            tx_b.push_back(fr[i]);
            tx_er.push_back(i == er_idx - 1);
        end
        for (int i = 0; i < n_exp; i++) begin
            exp_data.push_back(fr[i]);
            exp_code.push_back(i == n_exp - 1 ? last : (i == 0 ? PCC_SOP : PCC_DATA));
        end
    endtask

    task automatic drive_tx(input int stop_at);
        int n;
        n = (stop_at < 0) ? tx_b.size() : stop_at;
        for (int i = 0; i < n; i++) begin
            gmii_rx_dv = 1'b1;
            gmii_rxd   = tx_b[i];
            gmii_rx_er = tx_er[i];
            @(posedge clk); #1;
        end
        if (stop_at < 0) begin
            gmii_rx_dv = 1'b0;
            gmii_rx_er = 1'b0;
            gmii_rxd   = 8'h00;
            @(posedge clk); #1;
        end
    endtask

    task automatic clear_all();
        rx_code.delete();
        rx_data.delete();
        exp_code.delete();
        exp_data.delete();
        crc_seen = 0;
    endtask

    task automatic check_stream(input string name);
        int n;
        chk({name, " count"}, rx_code.size(), exp_code.size());
        n = (rx_code.size() < exp_code.size()) ? rx_code.size() : exp_code.size();
        for (int i = 0; i < n; i++)
            chk($sformatf("%s byte%0d", name, i), {rx_code[i], rx_data[i]}, {exp_code[i], exp_data[i]});
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached, errors=%0d", nerr);
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0] = '{64,  1'b0, -1, 8'hD5, 60, PCC_EOP,    0, 0};
        tbl[1] = '{64,  1'b1, -1, 8'hD5, 60, PCC_BADEOP, 1, 0};
        tbl[2] = '{40,  1'b0, -1, 8'hD5, 36, PCC_BADEOP, 0, 0};
        tbl[3] = '{3,   1'b0, -1, 8'hD5, 0,  PCC_EOP,    0, 1};
        tbl[4] = '{64,  1'b0, 20, 8'hD5, 60, PCC_BADEOP, 0, 0};
        tbl[5] = '{64,  1'b0, -1, 8'h5D, 0,  PCC_EOP,    0, 1};
        tbl[6] = '{5,   1'b0, -1, 8'hD5, 1,  PCC_BADEOP, 0, 0};
        tbl[7] = '{100, 1'b0, -1, 8'hD5, 96, PCC_EOP,    0, 0};
        tbl[8] = '{4,   1'b0, -1, 8'hD5, 0,  PCC_EOP,    0, 1};
        tbl[9] = '{5,   1'b1, -1, 8'hD5, 1,  PCC_BADEOP, 1, 0};

        reset_n     = 1'b0;
        gmii_rx_dv  = 1'b0;
        gmii_rx_er  = 1'b0;
        gmii_rxd    = 8'h00;
        rxg_if.drdy = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("reset srdy", rxg_if.srdy, 0);
        chk("reset crc_err", crc_err, 0);
        chk("reset drop_cnt", drop_cnt, 0);
        reset_n = 1'b1;
        @(posedge clk); #1;
        chk("post-reset srdy", rxg_if.srdy, 0);

        for (int k = 0; k < 10; k++) begin
            clear_all();
            build_frame(tbl[k].len, tbl[k].flip, tbl[k].er_idx, tbl[k].sfd, k,
                        tbl[k].n_exp, tbl[k].last);
            drive_tx(-1);
            repeat (12) @(posedge clk);
            #1;
            check_stream($sformatf("t%0d", k));
            chk($sformatf("t%0d crc_err pulses", k), crc_seen, tbl[k].crc_errs);
            exp_drop += tbl[k].drops;
            chk($sformatf("t%0d drop_cnt", k), drop_cnt, exp_drop);
        end

        // Overflow: no drain during a long frame, then a frame with no room.
        clear_all();
        rxg_if.drdy = 1'b0;
        build_frame(100, 1'b0, -1, 8'hD5, 20, 15, PCC_BADEOP);
        drive_tx(-1);
        repeat (3) @(posedge clk);
        #1;
        chk("ovf srdy held", rxg_if.srdy, 1);
        chk("ovf head code", rxg_if.code, PCC_SOP);
        build_frame(64, 1'b0, -1, 8'hD5, 21, 0, PCC_EOP);
        drive_tx(-1);
        repeat (3) @(posedge clk);
        #1;
        exp_drop++;
        chk("ovf drop_cnt", drop_cnt, exp_drop);
        rxg_if.drdy = 1'b1;
        repeat (25) @(posedge clk);
        #1;
        check_stream("ovf");
        chk("ovf drained srdy", rxg_if.srdy, 0);
        chk("ovf crc_err pulses", crc_seen, 0);

        // Back-to-back frames with a single idle cycle between them.
        clear_all();
        build_frame(64, 1'b0, -1, 8'hD5, 30, 60, PCC_EOP);
        drive_tx(-1);
        build_frame(64, 1'b0, -1, 8'hD5, 31, 60, PCC_EOP);
        drive_tx(-1);
        repeat (12) @(posedge clk);
        #1;
        check_stream("b2b");
        chk("b2b crc_err pulses", crc_seen, 0);

        // Reset in the middle of a frame, then a clean frame.
        clear_all();
        build_frame(64, 1'b0, -1, 8'hD5, 40, 0, PCC_EOP);
        drive_tx(8 + 30);
        chk("midrst srdy before", rxg_if.srdy, 1);
        reset_n    = 1'b0;
        gmii_rx_dv = 1'b0;
        gmii_rx_er = 1'b0;
        @(posedge clk); #1;
        chk("midrst srdy", rxg_if.srdy, 0);
        chk("midrst drop_cnt", drop_cnt, 0);
        exp_drop = 0;
        @(posedge clk); #1;
        reset_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        clear_all();
        build_frame(64, 1'b0, -1, 8'hD5, 41, 60, PCC_EOP);
        drive_tx(-1);
        repeat (12) @(posedge clk);
        #1;
        check_stream("after_rst");
        chk("after_rst crc_err pulses", crc_seen, 0);
        chk("after_rst drop_cnt", drop_cnt, exp_drop);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
